// File: rtl/pipe_stage_skid.sv
// Inter-stage pipeline register with a 2-entry skid buffer.
// Valid/ready handshake, flush with bubble insertion, saturating stall counter.
module pipe_stage_skid #(
    parameter int                  INSTR_W     = 16,
    parameter int                  CTRL_W      = 12,
    parameter int                  DATA_W      = 96,
    parameter logic [INSTR_W-1:0]  NOP_INSTR   = INSTR_W'(16'h0800),
    parameter int                  STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,

    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [INSTR_W-1:0]     in_instr,
    input  logic [CTRL_W-1:0]      in_ctrl,
    input  logic [DATA_W-1:0]      in_data,

    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [INSTR_W-1:0]     out_instr,
    output logic [CTRL_W-1:0]      out_ctrl,
    output logic [DATA_W-1:0]      out_data,

    output logic [STALL_CNT_W-1:0] stall_cnt,
    input  logic                   clr_stall_cnt
);

    // bit 0 = main valid, bit 1 = skid valid
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        FULL  = 2'b11
    } state_e;

    state_e                   state_q, state_d;
    logic                     in_ready_q, in_ready_d;

    logic [INSTR_W-1:0]       main_instr_q, main_instr_d;
    logic [CTRL_W-1:0]        main_ctrl_q,  main_ctrl_d;
    logic [DATA_W-1:0]        main_data_q,  main_data_d;

    logic [INSTR_W-1:0]       skid_instr_q, skid_instr_d;
    logic [CTRL_W-1:0]        skid_ctrl_q,  skid_ctrl_d;
    logic [DATA_W-1:0]        skid_data_q,  skid_data_d;

    logic [STALL_CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

    logic                     main_vld;
    logic                     in_fire;
    logic                     out_fire;
    logic                     ld_main_in;
    logic                     ld_main_skid;
    logic                     ld_skid_in;

    assign main_vld = state_q[0];
    assign in_fire  = in_valid & in_ready_q & ~flush;
    assign out_fire = main_vld & out_ready;

    // State register; in_ready is registered from the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
        end
    end

    // Next-state and load-select logic
    always_comb begin
        state_d      = state_q;
        ld_main_in   = 1'b0;
        ld_main_skid = 1'b0;
        ld_skid_in   = 1'b0;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        ld_main_in = 1'b1;
                        state_d    = ONE;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        ld_main_in = 1'b1;
                    end else if (in_fire) begin
                        ld_skid_in = 1'b1;
                        state_d    = FULL;
                    end else if (out_fire) begin
                        state_d    = EMPTY;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        ld_main_skid = 1'b1;
                        state_d      = ONE;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
        in_ready_d = (state_d != FULL);
    end

    // Payload next-state: main takes input or the older skid entry
    always_comb begin
        main_instr_d = main_instr_q;
        main_ctrl_d  = main_ctrl_q;
        main_data_d  = main_data_q;
        skid_instr_d = skid_instr_q;
        skid_ctrl_d  = skid_ctrl_q;
        skid_data_d  = skid_data_q;
        if (ld_main_in) begin
            main_instr_d = in_instr;
            main_ctrl_d  = in_ctrl;
            main_data_d  = in_data;
        end else if (ld_main_skid) begin
            main_instr_d = skid_instr_q;
            main_ctrl_d  = skid_ctrl_q;
            main_data_d  = skid_data_q;
        end
        if (ld_skid_in) begin
            skid_instr_d = in_instr;
            skid_ctrl_d  = in_ctrl;
            skid_data_d  = in_data;
        end
    end

    // Payload registers; stale contents survive flush, gating hides them
    always_ff @(posedge clk) begin
        if (rst) begin
            main_instr_q <= '0;
            main_ctrl_q  <= '0;
            main_data_q  <= '0;
            skid_instr_q <= '0;
            skid_ctrl_q  <= '0;
            skid_data_q  <= '0;
        end else begin
            main_instr_q <= main_instr_d;
            main_ctrl_q  <= main_ctrl_d;
            main_data_q  <= main_data_d;
            skid_instr_q <= skid_instr_d;
            skid_ctrl_q  <= skid_ctrl_d;
            skid_data_q  <= skid_data_d;
        end
    end

    // Stall counter next-state: clear wins, otherwise saturating increment
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (clr_stall_cnt) begin
            stall_cnt_d = '0;
        end else if (main_vld && !out_ready && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
        end
    end

    // Stall counter register; flush leaves it alone
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Output decode with bubble gating on the main register
    always_comb begin
        out_valid = main_vld;
        out_instr = main_vld ? main_instr_q : NOP_INSTR;
        out_ctrl  = main_vld ? main_ctrl_q  : '0;
        out_data  = main_data_q;
        in_ready  = in_ready_q;
        stall_cnt = stall_cnt_q;
    end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed vector bench for pipe_stage_skid.
// Uses STALL_CNT_W=4 so counter saturation is reachable quickly.
module tb_pipe_stage_skid;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_instr = '0;
    logic [11:0] in_ctrl = '0;
    logic [95:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_instr;
    logic [11:0] out_ctrl;
    logic [95:0] out_data;
    logic [3:0]  stall_cnt;
    logic        clr_stall_cnt = 1'b0;

    pipe_stage_skid #(
        .INSTR_W    (16),
        .CTRL_W     (12),
        .DATA_W     (96),
        .NOP_INSTR  (16'h0800),
        .STALL_CNT_W(4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_instr     (in_instr),
        .in_ctrl      (in_ctrl),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_instr    (out_instr),
        .out_ctrl     (out_ctrl),
        .out_data     (out_data),
        .stall_cnt    (stall_cnt),
        .clr_stall_cnt(clr_stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, fl, iv;
        logic [15:0] ii;
        logic        ordy, clr;
        logic        ev;
        logic [15:0] ei;
        logic        erdy;
        logic [3:0]  ecnt;
    } vec_t;

    vec_t v[$];
    int   nvec = 0;
    int   nerr = 0;

    function automatic logic [11:0] fc(logic [15:0] i);
        return i[11:0] ^ 12'h5A5;
    endfunction

    function automatic logic [95:0] fd(logic [15:0] i);
        return {6{i}};
    endfunction

    function automatic void add(logic r, logic f, logic iv, logic [15:0] ii,
                                logic o, logic c, logic ev, logic [15:0] ei,
                                logic erdy, logic [3:0] ecnt);
        vec_t t;
        t = '{r, f, iv, ii, o, c, ev, ei, erdy, ecnt};
        v.push_back(t);
    endfunction

    task automatic chk(string nm, int idx, logic [127:0] act, logic [127:0] exp);
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s vec=%0d actual=%h required=%h", nm, idx, act, exp);
        end
    endtask

    task automatic drive(logic r, logic f, logic iv, logic [15:0] ii,
                         logic o, logic c);
        rst           = r;
        flush         = f;
        in_valid      = iv;
        in_instr      = ii;
        in_ctrl       = fc(ii);
        in_data       = fd(ii);
        out_ready     = o;
        clr_stall_cnt = c;
    endtask

    initial begin
        logic [15:0] nop;
        nop = 16'h0800;

        // reset
        add(1,0,0,16'h0000, 0,0, 0,nop,    1,4'd0);
        // stream A..D with out_ready=1
        add(0,0,1,16'h1111, 1,0, 1,16'h1111,1,4'd0);
        add(0,0,1,16'h2222, 1,0, 1,16'h2222,1,4'd0);
        add(0,0,1,16'h3333, 1,0, 1,16'h3333,1,4'd0);
        add(0,0,1,16'h4444, 1,0, 1,16'h4444,1,4'd0);
        add(0,0,0,16'h0000, 1,0, 0,nop,    1,4'd0);
        // A loaded, B goes to skid, hold 3, drain
        add(0,0,1,16'h1111, 0,0, 1,16'h1111,1,4'd0);
        add(0,0,1,16'h2222, 0,0, 1,16'h1111,0,4'd1);
        add(0,0,1,16'h3333, 0,0, 1,16'h1111,0,4'd2);
        add(0,0,0,16'h0000, 0,0, 1,16'h1111,0,4'd3);
        add(0,0,0,16'h0000, 0,0, 1,16'h1111,0,4'd4);
        add(0,0,0,16'h0000, 1,0, 1,16'h2222,1,4'd4);
        add(0,0,0,16'h0000, 1,0, 0,nop,    1,4'd4);
        // fill to FULL, flush with C offered
        add(0,0,1,16'h1111, 0,0, 1,16'h1111,1,4'd4);
        add(0,0,1,16'h2222, 0,0, 1,16'h1111,0,4'd5);
        add(0,1,1,16'h3333, 0,0, 0,nop,    1,4'd6);
        add(0,0,0,16'h0000, 1,0, 0,nop,    1,4'd6);
        add(0,0,0,16'h0000, 1,1, 0,nop,    1,4'd0);
        // simultaneous in_fire/out_fire in ONE for 10 cycles
        add(0,0,1,16'h1001, 1,0, 1,16'h1001,1,4'd0);
        for (int k = 2; k <= 11; k++)
            add(0,0,1,16'h1000 + 16'(k), 1,0, 1,16'h1000 + 16'(k),1,4'd0);
        add(0,0,0,16'h0000, 1,0, 0,nop,    1,4'd0);
        // saturation with a 4-bit counter, then clear while stalling
        add(0,0,1,16'h2222, 0,0, 1,16'h2222,1,4'd0);
        for (int k = 1; k <= 20; k++)
            add(0,0,0,16'h0000, 0,0, 1,16'h2222,1, (k > 15) ? 4'd15 : 4'(k));
        add(0,0,0,16'h0000, 0,1, 1,16'h2222,1,4'd0);
        add(0,0,0,16'h0000, 0,0, 1,16'h2222,1,4'd1);
        // reset while FULL
        add(0,0,1,16'h3333, 0,0, 1,16'h2222,0,4'd2);
        add(1,0,0,16'h0000, 0,0, 0,nop,    1,4'd0);
        add(0,0,0,16'h0000, 1,0, 0,nop,    1,4'd0);
        add(0,0,0,16'h0000, 1,0, 0,nop,    1,4'd0);
        // flush coinciding with out_fire
        add(0,0,1,16'h4444, 1,0, 1,16'h4444,1,4'd0);
        add(0,1,1,16'h5555, 1,0, 0,nop,    1,4'd0);
        add(0,0,0,16'h0000, 1,0, 0,nop,    1,4'd0);

        @(negedge clk);
        foreach (v[i]) begin
            drive(v[i].rst, v[i].fl, v[i].iv, v[i].ii, v[i].ordy, v[i].clr);
            @(posedge clk);
            #1;
            nvec++;
            chk("out_valid", i, 128'(out_valid), 128'(v[i].ev));
            chk("out_instr", i, 128'(out_instr), 128'(v[i].ei));
            chk("out_ctrl",  i, 128'(out_ctrl),
                128'(v[i].ev ? fc(v[i].ei) : 12'h000));
            chk("in_ready",  i, 128'(in_ready),  128'(v[i].erdy));
            chk("stall_cnt", i, 128'(stall_cnt), 128'(v[i].ecnt));
            if (v[i].ev)
                chk("out_data", i, 128'(out_data), 128'(fd(v[i].ei)));
            else if (v[i].rst)
                chk("out_data_rst", i, 128'(out_data), 128'(0));
            @(negedge clk);
        end

        // in_ready must not react combinationally to out_ready/in_valid/flush
        drive(0,0,1,16'h6666, 0,0);
        @(posedge clk);
        @(negedge clk);
        drive(0,0,1,16'h7777, 0,0);
        @(posedge clk);
        #1;
        nvec++;
        chk("full_rdy", 900, 128'(in_ready), 128'(0));
        drive(0,1,0,16'h0000, 1,0);
        #1;
        nvec++;
        chk("rdy_nocomb", 901, 128'(in_ready), 128'(0));
        @(posedge clk);
        #1;
        nvec++;
        chk("flush_rdy", 902, 128'(in_ready), 128'(1));
        chk("flush_vld", 902, 128'(out_valid), 128'(0));
        chk("flush_nop", 902, 128'(out_instr), 128'(nop));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
